// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: sequencer states
// and instruction geometry.
package fetch_pkg;

    localparam int INST_W         = 32;
    localparam int BYTES_PER_INST = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_INST);

    // FETCH issues one byte read per cycle, DRAIN collects the last byte,
    // VALID presents the assembled instruction until it is accepted.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch sequencer: reads a 32-bit instruction one byte at a time
// from a byte-wide memory with one cycle of read latency, assembles it
// big-endian and hands it downstream over a valid/ready handshake. A redirect
// request restarts fetching at a new word-aligned PC from any state.
module inst_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [31:0]       pc_out
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_INST - 1);

    fetch_state_e          state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           pc_out_q, pc_out_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [INST_W-1:0]     inst_q, inst_d;
    // Low during reset and for the first edge after it, so no read is issued
    // until the cycle that follows the first rising edge out of reset.
    logic                  run_q;
    logic                  capture;
    logic [BYTE_IDX_W-1:0] slot;

    // State register and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            idx_q    <= '0;
            inst_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            idx_q    <= idx_d;
            inst_q   <= inst_d;
            run_q    <= 1'b1;
        end
    end

    // Next-state logic: byte sequencing, assembly, handshake and redirect.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        idx_d    = idx_q;
        inst_d   = inst_q;
        capture  = 1'b0;
        // The byte arriving now was issued one cycle ago, i.e. for idx_q-1;
        // in DRAIN idx_q has wrapped to 0, so this lands on the last byte.
        slot     = idx_q - 1'b1;

        unique case (state_q)
            FETCH: begin
                if (run_q) begin
                    capture = (idx_q != '0);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                capture  = 1'b1;
                pc_out_d = pc_q;
                state_d  = VALID;
            end
            VALID: begin
                if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (capture) begin
            inst_d[INST_W - 1 - 8 * int'(slot) -: 8] = mem_rdata;
        end

        // A redirect wins over everything, drops the byte arriving this cycle
        // and restarts at the word-aligned target.
        if (redirect_valid) begin
            state_d  = FETCH;
            pc_d     = redirect_pc & ~32'd3;
            idx_d    = '0;
            inst_d   = inst_q;
            pc_out_d = pc_out_q;
        end
    end

    assign mem_rd_en  = run_q && (state_q == FETCH);
    assign mem_addr   = pc_q[MEM_AW-1:0] + MEM_AW'(idx_q);
    assign inst_valid = (state_q == VALID);
    assign inst_out   = inst_q;
    assign pc_out     = pc_out_q;

endmodule
